// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the word-level UART TX arbiter and the
// CPU communication controller: FSM state encoding, byte width, command codes.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    // Command/response codes exchanged with the host over the UART link.
    localparam logic [7:0] CMD_RESET   = 8'd1;
    localparam logic [7:0] CMD_SEND_PC = 8'd2;
    localparam logic [7:0] RSP_READY   = 8'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Index width for a set of n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit above last_grant, wrapping.
// Ports: req, last_grant in; gnt (one-hot) and gnt_idx out.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        int   c;
        logic found;
        c       = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        // Search starts one past the last winner, so that winner ranks last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req[c[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[c[IDX_W-1:0]]     = 1'b1;
                gnt_idx               = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_word_tx_arbiter.sv
// Shares one byte UART TX among NUM_REQ word requesters, round-robin.
// Ports: clk, reset, req, req_data in; done, busy, grant_idx out;
// byte_data/byte_valid out with byte_ready in (valid/ready handshake).
module uart_word_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WORD_BYTES = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*8*WORD_BYTES-1:0]    req_data,
    output logic [NUM_REQ-1:0]                 done,
    output logic                               busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_idx,
    output logic [7:0]                         byte_data,
    output logic                               byte_valid,
    input  logic                               byte_ready
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int CNT_W  = idx_w(WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);
    localparam logic [IDX_W-1:0] RST_GRANT = IDX_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [WORD_W-1:0]  win_word;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    // One-hot AND-OR mux of the winning requester's word.
    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_word = win_word | req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            grant_idx_q  <= RST_GRANT;
            last_grant_q <= RST_GRANT;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = SEND;
                    shift_d     = win_word;
                    grant_idx_d = arb_idx;
                    cnt_d       = '0;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    // Move the next byte into the output position.
                    if (MSB_FIRST) begin
                        shift_d = shift_q << BYTE_W;
                    end else begin
                        shift_d = shift_q >> BYTE_W;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_grant_d = grant_idx_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        done = '0;
        if (state_q == DONE) begin
            done[grant_idx_q] = 1'b1;
        end
    end

    assign busy       = (state_q != IDLE);
    assign byte_valid = (state_q == SEND);
    assign grant_idx  = grant_idx_q;
    assign byte_data  = MSB_FIRST ? shift_q[WORD_W-1 -: BYTE_W]
                                  : shift_q[BYTE_W-1:0];

endmodule

// File: tb/tb_uart_word_tx_arbiter.sv
// Scoreboard bench for uart_word_tx_arbiter: LSB-first and MSB-first builds.
// Stimulus pushes expected bytes/done indices; monitors pop and compare.
module tb_uart_word_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] req_data;
    logic [1:0]  done;
    logic        busy;
    logic [0:0]  grant_idx;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;

    logic [1:0]  m_req;
    logic [63:0] m_data;
    logic [1:0]  m_done;
    logic        m_busy;
    logic [0:0]  m_grant;
    logic [7:0]  m_byte;
    logic        m_valid;
    logic        m_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_bytes[$];
    int         exp_done[$];
    logic [7:0] m_exp_bytes[$];
    int         m_exp_done[$];

    always #5 clk = ~clk;

    uart_word_tx_arbiter #(
        .NUM_REQ(2), .WORD_BYTES(4), .MSB_FIRST(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .done(done), .busy(busy), .grant_idx(grant_idx),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready)
    );

    uart_word_tx_arbiter #(
        .NUM_REQ(2), .WORD_BYTES(4), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk(clk), .reset(reset), .req(m_req), .req_data(m_data),
        .done(m_done), .busy(m_busy), .grant_idx(m_grant),
        .byte_data(m_byte), .byte_valid(m_valid),
        .byte_ready(m_ready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input int idx);
        for (int i = 0; i < 4; i++) exp_bytes.push_back(w[i*8 +: 8]);
        exp_done.push_back(idx);
    endtask

    // Steps until done is seen; returns the number of steps taken.
    task automatic wait_done(output int n);
        n = 0;
        while (done == 2'b00 && n < 60) begin
            step();
            n++;
        end
        chk("done_timeout", {31'b0, done != 2'b00}, 32'd1);
    endtask

    // Transfer monitor, default build.
    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid && byte_ready) begin
                if (exp_bytes.size() == 0) begin
                    chk("sb_unexpected_byte", {24'b0, byte_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_byte", {24'b0, byte_data},
                        {24'b0, exp_bytes.pop_front()});
                end
            end
            if (done != 2'b00) begin
                chk("sb_done_onehot", {31'b0, $onehot(done)}, 32'd1);
                if (exp_done.size() == 0) begin
                    chk("sb_unexpected_done", {30'b0, done}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_done", {30'b0, done},
                        32'd1 << exp_done.pop_front());
                end
            end
        end
    end

    // Transfer monitor, MSB-first build.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                if (m_exp_bytes.size() == 0) begin
                    chk("msb_unexpected_byte", {24'b0, m_byte}, 32'hFFFF_FFFF);
                end else begin
                    chk("msb_byte", {24'b0, m_byte},
                        {24'b0, m_exp_bytes.pop_front()});
                end
            end
            if (m_done != 2'b00) begin
                if (m_exp_done.size() == 0) begin
                    chk("msb_unexpected_done", {30'b0, m_done}, 32'hFFFF_FFFF);
                end else begin
                    chk("msb_done", {30'b0, m_done},
                        32'd1 << m_exp_done.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        reset      = 1'b1;
        req        = 2'b00;
        req_data   = '0;
        byte_ready = 1'b1;
        m_req      = 2'b00;
        m_data     = '0;
        m_ready    = 1'b1;
        step();
        step();
        chk("rst_valid", {31'b0, byte_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {30'b0, done}, 32'd0);
        chk("rst_data", {24'b0, byte_data}, 32'd0);
        chk("rst_grant", {31'b0, grant_idx}, 32'd1);
        reset = 1'b0;
        step();

        // Single request, ready tied high: exact timing.
        push_word(32'h0000_0003, 0);
        req_data[31:0] = 32'h0000_0003;
        req = 2'b01;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", {31'b0, byte_valid}, 32'd1);
            chk("t1_busy", {31'b0, busy}, 32'd1);
            step();
        end
        chk("t1_done", {30'b0, done}, 32'd1);
        chk("t1_valid_off", {31'b0, byte_valid}, 32'd0);
        req = 2'b00;
        step();
        chk("t1_busy_off", {31'b0, busy}, 32'd0);
        chk("t1_done_off", {30'b0, done}, 32'd0);

        // Both requesting after reset: 0 first, then alternating.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_data = {32'h1234_5678, 32'h0000_0003};
        push_word(32'h0000_0003, 0);
        push_word(32'h1234_5678, 1);
        push_word(32'h0000_0003, 0);
        push_word(32'h1234_5678, 1);
        req = 2'b11;
        for (int w = 0; w < 4; w++) begin
            wait_done(n);
            chk("rr_grant", {31'b0, grant_idx}, w % 2);
            if (w == 3) req = 2'b00;
            step();
        end
        chk("rr_idle", {31'b0, busy}, 32'd0);

        // Backpressure on byte 2 for three cycles.
        req_data[31:0] = 32'hA1B2_C3D4;
        push_word(32'hA1B2_C3D4, 0);
        req = 2'b01;
        step();
        n = 0;
        while (done == 2'b00 && n < 60) begin
            step();
            n++;
            if (n == 2) byte_ready = 1'b0;
            if (n >= 2 && n <= 4) begin
                chk("bp_valid", {31'b0, byte_valid}, 32'd1);
                chk("bp_hold", {24'b0, byte_data}, 32'hB2);
            end
            if (n == 5) byte_ready = 1'b1;
        end
        chk("bp_latency", n, 32'd7);
        req = 2'b00;
        step();

        // Data change after grant is ignored.
        req_data[31:0] = 32'h1122_3344;
        push_word(32'h1122_3344, 0);
        req = 2'b01;
        step();
        req_data[31:0] = 32'hFFFF_FFFF;
        wait_done(n);
        req = 2'b00;
        step();

        // Reset mid-word, then pending req[1] wins with req[0] low.
        req_data = {32'h0A0B_0C0D, 32'h5566_7788};
        exp_bytes.push_back(8'h88);
        req = 2'b01;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, byte_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {30'b0, done}, 32'd0);
        chk("mid_rst_grant", {31'b0, grant_idx}, 32'd1);
        chk("mid_rst_q", exp_bytes.size(), 32'd0);
        req = 2'b10;
        push_word(32'h0A0B_0C0D, 1);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_grant", {31'b0, grant_idx}, 32'd1);
        chk("post_rst_busy", {31'b0, busy}, 32'd1);
        wait_done(n);
        req = 2'b00;
        step();

        // MSB-first build.
        m_data[31:0] = 32'h1234_5678;
        m_exp_bytes.push_back(8'h12);
        m_exp_bytes.push_back(8'h34);
        m_exp_bytes.push_back(8'h56);
        m_exp_bytes.push_back(8'h78);
        m_exp_done.push_back(0);
        m_req = 2'b01;
        n = 0;
        while (m_done == 2'b00 && n < 60) begin
            step();
            n++;
        end
        chk("msb_latency", n, 32'd5);
        m_req = 2'b00;
        step();
        step();
        chk("msb_busy_off", {31'b0, m_busy}, 32'd0);

        chk("sb_bytes_left", exp_bytes.size(), 32'd0);
        chk("sb_done_left", exp_done.size(), 32'd0);
        chk("msb_bytes_left", m_exp_bytes.size(), 32'd0);
        chk("msb_done_left", m_exp_done.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
